// File: rtl/sdatapath_pipe_pkg.sv
// Shared types for the pipelined signed compare/shift datapath.
package sdp_pkg;

    localparam int unsigned MODE_W = 2;
    localparam int unsigned DW_MIN = 4;
    localparam int unsigned DW_MAX = 64;

    // Per-beat operation mode, sampled together with the operands.
    typedef enum logic [MODE_W-1:0] {
        MODE_LEGACY = 2'd0,
        MODE_VSHIFT = 2'd1,
        MODE_MINMAX = 2'd2,
        MODE_PASS   = 2'd3
    } mode_e;

endpackage

// File: rtl/sdatapath_pipe_if.sv
// Operand/result handshake bundle between source, datapath and consumer.
interface sdatapath_pipe_if #(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned CNTWIDTH  = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [1:0]                  mode;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic signed [DATAWIDTH-1:0] c;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [DATAWIDTH-1:0] x;
    logic signed [DATAWIDTH-1:0] z;
    logic                        lt_flag;
    logic                        eq_flag;
    logic [CNTWIDTH-1:0]         done_cnt;

    // Source/consumer side.
    modport master (
        output in_valid, mode, a, b, c, out_ready,
        input  in_ready, out_valid, x, z, lt_flag, eq_flag, done_cnt
    );

    // Datapath side.
    modport slave (
        input  in_valid, mode, a, b, c, out_ready,
        output in_ready, out_valid, x, z, lt_flag, eq_flag, done_cnt
    );
endinterface

// File: rtl/sdatapath_pipe_stage_reg.sv
// Valid+payload pipeline register: holds while disabled, sync clear.
module sdp_stage_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);
    logic         valid_q;
    logic [W-1:0] data_q;

    // Advance on enable; payload only captured for real beats so the last result stays visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (en_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/sdatapath_pipe.sv
// Three-stage signed add/compare/shift datapath with backpressure and a saturating completion counter.
module sdatapath_pipe
    import sdp_pkg::*;
#(
    parameter int unsigned DATAWIDTH = 32,
    parameter int unsigned CNTWIDTH  = 16
) (
    input  logic            clk,
    input  logic            rst,
    sdatapath_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(DATAWIDTH);

    typedef logic signed [DATAWIDTH-1:0] word_t;

    // S1 -> S2 beat: sums plus the fields later stages still need.
    typedef struct packed {
        word_t          d;
        word_t          e;
        word_t          f;
        logic [SHW-1:0] camt;
        mode_e          mode;
    } s1_beat_t;

    // S2 -> S3 beat: compare result, selected operands and shift amounts.
    typedef struct packed {
        logic           lt;
        logic           eq;
        word_t          sel_x;
        word_t          sel_z;
        logic [SHW-1:0] shl_amt;
        logic [SHW-1:0] shr_amt;
    } s2_beat_t;

    // S3 beat: presented result.
    typedef struct packed {
        word_t x;
        word_t z;
        logic  lt;
        logic  eq;
    } s3_beat_t;

    if (DATAWIDTH < DW_MIN || DATAWIDTH > DW_MAX) begin : g_bad_width
        $error("sdatapath_pipe: DATAWIDTH out of range");
    end

    s1_beat_t            s1_d, s1_q;
    s2_beat_t            s2_d, s2_q;
    s3_beat_t            s3_d, s3_q;
    logic                s1_valid, s2_valid, s3_valid;
    logic                stall_c;
    logic                advance_c;
    logic                accept_c;
    logic                lt_c, eq_c;
    logic [CNTWIDTH-1:0] cnt_q;

    // Whole pipe freezes while the consumer refuses a presented result.
    assign stall_c   = s3_valid && !bus.out_ready;
    assign advance_c = !stall_c;
    assign accept_c  = bus.in_valid && advance_c;

    // S1: wrap-around sums and difference.
    always_comb begin
        s1_d      = '0;
        s1_d.d    = bus.a + bus.b;
        s1_d.e    = bus.a + bus.c;
        s1_d.f    = bus.a - bus.b;
        s1_d.camt = bus.c[SHW-1:0];
        s1_d.mode = mode_e'(bus.mode);
    end

    // S2: signed compare, operand select and shift amounts per mode.
    always_comb begin
        lt_c = $signed(s1_q.d) < $signed(s1_q.e);
        eq_c = s1_q.d == s1_q.e;
        s2_d    = '0;
        s2_d.lt = lt_c;
        s2_d.eq = eq_c;
        case (s1_q.mode)
            MODE_LEGACY: begin
                s2_d.sel_x   = s1_q.d;
                s2_d.sel_z   = s1_q.d;
                s2_d.shl_amt = SHW'(lt_c);
                s2_d.shr_amt = SHW'(eq_c);
            end
            MODE_VSHIFT: begin
                s2_d.sel_x   = s1_q.d;
                s2_d.sel_z   = s1_q.d;
                s2_d.shl_amt = s1_q.camt;
                s2_d.shr_amt = s1_q.camt;
            end
            MODE_MINMAX: begin
                // Tie falls to the e/d legs, which are equal, so both outputs carry d.
                s2_d.sel_x = lt_c ? s1_q.d : s1_q.e;
                s2_d.sel_z = lt_c ? s1_q.e : s1_q.d;
            end
            MODE_PASS: begin
                s2_d.sel_x = s1_q.f;
                s2_d.sel_z = s1_q.d;
            end
            default: begin
                s2_d.sel_x = s1_q.d;
                s2_d.sel_z = s1_q.d;
            end
        endcase
    end

    // S3: logical left shift for x, arithmetic right shift for z.
    always_comb begin
        s3_d    = '0;
        s3_d.x  = s2_q.sel_x << s2_q.shl_amt;
        s3_d.z  = $signed(s2_q.sel_z) >>> s2_q.shr_amt;
        s3_d.lt = s2_q.lt;
        s3_d.eq = s2_q.eq;
    end

    sdp_stage_reg #(.W($bits(s1_beat_t))) u_s1 (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance_c),
        .valid_i (accept_c),
        .data_i  (s1_d),
        .valid_o (s1_valid),
        .data_o  (s1_q)
    );

    sdp_stage_reg #(.W($bits(s2_beat_t))) u_s2 (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance_c),
        .valid_i (s1_valid),
        .data_i  (s2_d),
        .valid_o (s2_valid),
        .data_o  (s2_q)
    );

    sdp_stage_reg #(.W($bits(s3_beat_t))) u_s3 (
        .clk     (clk),
        .rst     (rst),
        .en_i    (advance_c),
        .valid_i (s2_valid),
        .data_i  (s3_d),
        .valid_o (s3_valid),
        .data_o  (s3_q)
    );

    // Completed-transfer counter, sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (s3_valid && bus.out_ready && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNTWIDTH'(1);
        end
    end

    assign bus.in_ready  = advance_c;
    assign bus.out_valid = s3_valid;
    assign bus.x         = s3_q.x;
    assign bus.z         = s3_q.z;
    assign bus.lt_flag   = s3_q.lt;
    assign bus.eq_flag   = s3_q.eq;
    assign bus.done_cnt  = cnt_q;
endmodule

// File: tb/tb_sdatapath_pipe.sv
// Randomised and directed bench for sdatapath_pipe against a plain-arithmetic reference model.
module tb_sdatapath_pipe;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 16;
    localparam int unsigned DW2 = 8;
    localparam int unsigned CW2 = 3;

    typedef struct {
        longint x;
        longint z;
        bit     lt;
        bit     eq;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sdatapath_pipe_if #(.DATAWIDTH(DW),  .CNTWIDTH(CW))  if1 ();
    sdatapath_pipe_if #(.DATAWIDTH(DW2), .CNTWIDTH(CW2)) if2 ();

    sdatapath_pipe #(.DATAWIDTH(DW),  .CNTWIDTH(CW))  u_dut  (.clk(clk), .rst(rst), .bus(if1));
    sdatapath_pipe #(.DATAWIDTH(DW2), .CNTWIDTH(CW2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   exp_cnt  = 0;
    int   accept_cyc = 0;
    bit   prev_stall = 1'b0;
    res_t prev_out;
    res_t exp_q[$];

    function automatic longint sx(input longint v, input int w);
        longint t;
        t = v <<< (64 - w);
        return t >>> (64 - w);
    endfunction

    // Reference: wrap to w bits, compare signed, pick operands and shifts by mode.
    function automatic res_t model(input int w, input logic [1:0] m, input longint a, input longint b, input longint c);
        res_t   r;
        longint d, e, f, px, pz;
        int     shw, amt, sl, sr;
        d = sx(a + b, w);
        e = sx(a + c, w);
        f = sx(a - b, w);
        shw = 0;
        while ((1 << shw) < w) shw++;
        amt = int'(c & ((64'sd1 <<< shw) - 64'sd1));
        r.lt = (d < e);
        r.eq = (d == e);
        case (m)
            2'd0:    begin px = d; pz = d; sl = int'(r.lt); sr = int'(r.eq); end
            2'd1:    begin px = d; pz = d; sl = amt; sr = amt; end
            2'd2:    begin px = r.lt ? d : e; pz = r.lt ? e : d; sl = 0; sr = 0; end
            default: begin px = f; pz = d; sl = 0; sr = 0; end
        endcase
        r.x = sx(px <<< sl, w);
        r.z = sx(pz >>> sr, w);
        return r;
    endfunction

    function automatic logic [31:0] rnd_word();
        if ($urandom_range(1) == 0) return $urandom();
        return 32'($urandom_range(16)) - 32'd8;
    endfunction

    // One clock on the 32-bit instance: drive at negedge, sample 1 ns later, scoreboard.
    task automatic cycle(input bit vld, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input bit ordy, output bit acc, output bit got, output res_t obs);
        res_t e;
        bit   exp_rdy;
        if1.in_valid  = vld;
        if1.mode      = m;
        if1.a         = a;
        if1.b         = b;
        if1.c         = c;
        if1.out_ready = ordy;
        #1;
        obs.x  = longint'($signed(if1.x));
        obs.z  = longint'($signed(if1.z));
        obs.lt = (if1.lt_flag === 1'b1);
        obs.eq = (if1.eq_flag === 1'b1);
        got     = (if1.out_valid === 1'b1) && ordy;
        acc     = vld && (if1.in_ready === 1'b1);
        exp_rdy = !((if1.out_valid === 1'b1) && !ordy);
        n_checks++;
        if (if1.in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL in_ready cyc=%0d got=%b want=%b", cyc, if1.in_ready, exp_rdy);
        end
        n_checks++;
        if (if1.done_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL done_cnt cyc=%0d got=%0d want=%0d", cyc, if1.done_cnt, exp_cnt);
        end
        if (prev_stall) begin
            n_checks++;
            if (if1.out_valid !== 1'b1 || obs.x != prev_out.x || obs.z != prev_out.z ||
                obs.lt != prev_out.lt || obs.eq != prev_out.eq) begin
                n_fail++;
                $display("FAIL hold cyc=%0d got v=%b x=%0d z=%0d want v=1 x=%0d z=%0d",
                         cyc, if1.out_valid, obs.x, obs.z, prev_out.x, prev_out.z);
            end
        end
        if (got) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL result cyc=%0d got unexpected x=%0d want nothing", cyc, obs.x);
            end else begin
                e = exp_q.pop_front();
                if (obs.x != e.x || obs.z != e.z || obs.lt != e.lt || obs.eq != e.eq) begin
                    n_fail++;
                    $display("FAIL result cyc=%0d got x=%0d z=%0d lt=%b eq=%b want x=%0d z=%0d lt=%b eq=%b",
                             cyc, obs.x, obs.z, obs.lt, obs.eq, e.x, e.z, e.lt, e.eq);
                end
            end
            if (exp_cnt < 65535) exp_cnt++;
        end
        if (acc) begin
            exp_q.push_back(model(32, m, longint'($signed(a)), longint'($signed(b)), longint'($signed(c))));
            accept_cyc = cyc;
        end
        prev_stall = !exp_rdy;
        prev_out   = obs;
        cyc++;
        @(negedge clk);
    endtask

    // Single beat against hand-computed constants, plus accept-to-valid latency.
    task automatic directed(input string name, input logic [1:0] m, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] c, input longint ex_x, input longint ex_z, input bit ex_lt, input bit ex_eq);
        bit   acc, got;
        bit   seen;
        res_t obs;
        int   acc_cyc;
        seen = 1'b0;
        cycle(1'b1, m, a, b, c, 1'b1, acc, got, obs);
        acc_cyc = accept_cyc;
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL %s accept got=0 want=1", name);
        end
        for (int i = 0; i < 8 && !seen; i++) begin
            cycle(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, got, obs);
            if (got) begin
                seen = 1'b1;
                n_checks++;
                if ((cyc - 1 - acc_cyc) != 3) begin
                    n_fail++;
                    $display("FAIL %s latency got=%0d want=3", name, cyc - 1 - acc_cyc);
                end
                n_checks++;
                if (obs.x != ex_x || obs.z != ex_z || obs.lt != ex_lt || obs.eq != ex_eq) begin
                    n_fail++;
                    $display("FAIL %s got x=%0d z=%0d lt=%b eq=%b want x=%0d z=%0d lt=%b eq=%b",
                             name, obs.x, obs.z, obs.lt, obs.eq, ex_x, ex_z, ex_lt, ex_eq);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout got no out_valid want one", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b1; if1.mode = 2'd0;
        if1.a = '0; if1.b = '0; if1.c = '0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b1; if2.mode = 2'd0;
        if2.a = '0; if2.b = '0; if2.c = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b want=0", if1.out_valid); end
        n_checks++; if (if1.x !== '0) begin n_fail++; $display("FAIL rst_x got=%h want=0", if1.x); end
        n_checks++; if (if1.z !== '0) begin n_fail++; $display("FAIL rst_z got=%h want=0", if1.z); end
        n_checks++; if (if1.lt_flag !== 1'b0 || if1.eq_flag !== 1'b0) begin n_fail++; $display("FAIL rst_flags got=%b%b want=00", if1.lt_flag, if1.eq_flag); end
        n_checks++; if (if1.done_cnt !== '0) begin n_fail++; $display("FAIL rst_done_cnt got=%0d want=0", if1.done_cnt); end
        n_checks++; if (if1.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b want=1", if1.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete(); exp_cnt = 0; prev_stall = 1'b0;
    endtask

    task automatic test_directed();
        directed("legacy_lt",   2'd0, 32'd5, 32'd3, 32'd10, 64'sd16, 64'sd8, 1'b1, 1'b0);
        directed("legacy_eq",   2'd0, 32'd5, 32'd7, 32'd7,  64'sd12, 64'sd6, 1'b0, 1'b1);
        directed("legacy_wrap", 2'd0, 32'h7FFF_FFFF, 32'd1, 32'd0, 64'sd0, -64'sd2147483648, 1'b1, 1'b0);
        directed("vshift",      2'd1, -32'sd16, 32'd0, 32'd2, -64'sd64, -64'sd4, 1'b1, 1'b0);
        directed("minmax",      2'd2, 32'd1, 32'd9, 32'd2, 64'sd3, 64'sd10, 1'b0, 1'b0);
        directed("minmax_tie",  2'd2, 32'd3, 32'd4, 32'd4, 64'sd7, 64'sd7, 1'b0, 1'b1);
        directed("pass",        2'd3, 32'd4, 32'd6, 32'd0, -64'sd2, 64'sd10, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        int   sent, comps, stalls, base;
        bit   acc, got, ordy;
        res_t obs;
        sent = 0; comps = 0; stalls = 0; base = exp_cnt;
        for (int i = 0; i < 40 && comps < 6; i++) begin
            ordy = !(i >= 4 && i <= 8);
            cycle(sent < 6, 2'($urandom_range(3)), rnd_word(), rnd_word(), rnd_word(), ordy, acc, got, obs);
            if (acc) sent++;
            if (got) comps++;
            if (prev_stall) stalls++;
        end
        n_checks++; if (comps != 6 || sent != 6) begin n_fail++; $display("FAIL bp_count got sent=%0d done=%0d want 6/6", sent, comps); end
        n_checks++; if (stalls == 0) begin n_fail++; $display("FAIL bp_stall got=0 stall cycles want>0"); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_left got=%0d want=0", exp_q.size()); end
        n_checks++; if (if1.done_cnt !== 16'(base + 6)) begin n_fail++; $display("FAIL bp_done_cnt got=%0d want=%0d", if1.done_cnt, base + 6); end
    endtask

    task automatic test_random();
        bit   acc, got;
        res_t obs;
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(3) != 0, 2'($urandom_range(3)), rnd_word(), rnd_word(), rnd_word(),
                  $urandom_range(3) != 0, acc, got, obs);
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            cycle(1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 1'b1, acc, got, obs);
        end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_drain got=%0d pending want=0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit   acc, got;
        res_t obs;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 2'($urandom_range(3)), rnd_word(), rnd_word(), rnd_word(), 1'b1, acc, got, obs);
        end
        rst = 1'b1;
        if1.in_valid = 1'b1; if1.a = 32'd11; if1.b = 32'd22; if1.c = 32'd33; if1.out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        if1.in_valid = 1'b0;
        #1;
        n_checks++; if (if1.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_out_valid got=%b want=0", if1.out_valid); end
        n_checks++; if (if1.x !== '0 || if1.z !== '0) begin n_fail++; $display("FAIL midrst_xz got x=%h z=%h want 0", if1.x, if1.z); end
        n_checks++; if (if1.done_cnt !== '0) begin n_fail++; $display("FAIL midrst_done_cnt got=%0d want=0", if1.done_cnt); end
        exp_q.delete(); exp_cnt = 0; prev_stall = 1'b0;
        @(negedge clk);
        directed("post_reset", 2'd0, 32'd5, 32'd3, 32'd10, 64'sd16, 64'sd8, 1'b1, 1'b0);
    endtask

    // 8-bit instance with a 3-bit counter: results and saturation at 7.
    task automatic test_saturation();
        res_t       q2[$];
        res_t       e;
        int         sent, comps;
        logic [7:0] a2, b2, c2;
        logic [1:0] m2;
        sent = 0; comps = 0;
        for (int i = 0; i < 60 && comps < 10; i++) begin
            a2 = 8'($urandom); b2 = 8'($urandom); c2 = 8'($urandom); m2 = 2'($urandom_range(3));
            if2.in_valid = (sent < 10); if2.mode = m2; if2.a = a2; if2.b = b2; if2.c = c2; if2.out_ready = 1'b1;
            #1;
            if (if2.out_valid === 1'b1) begin
                n_checks++;
                if (if2.done_cnt !== 3'((comps < 7) ? comps : 7)) begin
                    n_fail++;
                    $display("FAIL sat_progress got=%0d want=%0d", if2.done_cnt, (comps < 7) ? comps : 7);
                end
                n_checks++;
                if (q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL sat_result got unexpected beat want none");
                end else begin
                    e = q2.pop_front();
                    if (longint'($signed(if2.x)) != e.x || longint'($signed(if2.z)) != e.z ||
                        if2.lt_flag !== e.lt || if2.eq_flag !== e.eq) begin
                        n_fail++;
                        $display("FAIL sat_result got x=%0d z=%0d want x=%0d z=%0d",
                                 $signed(if2.x), $signed(if2.z), e.x, e.z);
                    end
                end
                comps++;
            end
            if (if2.in_valid && if2.in_ready === 1'b1) begin
                q2.push_back(model(8, m2, longint'($signed(a2)), longint'($signed(b2)), longint'($signed(c2))));
                sent++;
            end
            @(negedge clk);
        end
        if2.in_valid = 1'b0;
        n_checks++; if (comps != 10) begin n_fail++; $display("FAIL sat_count got=%0d want=10", comps); end
        n_checks++; if (if2.done_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_value got=%0d want=7", if2.done_cnt); end
        repeat (3) @(negedge clk);
        n_checks++; if (if2.done_cnt !== 3'd7) begin n_fail++; $display("FAIL sat_hold got=%0d want=7", if2.done_cnt); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
